// File: rtl/param_updown_counter_pkg.sv
// Shared constants for the up/down counter: direction encoding, default geometry, reset polarity.
package param_updown_counter_pkg;

    localparam logic DIR_UP     = 1'b1;
    localparam logic DIR_DOWN   = 1'b0;

    localparam int   DEF_WIDTH   = 4;
    localparam int   DEF_MODULUS = 16;

    localparam logic RST_ACTIVE = 1'b0;

endpackage

// File: rtl/param_updown_counter_dff_bank_arst.sv
// WIDTH-bit D register with asynchronous active-low reset to a parameterised value.
module dff_bank_arst
    import param_updown_counter_pkg::*;
#(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (rst_ni == RST_ACTIVE) begin
            q_o <= RST_VAL;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised modulo up/down counter with load, terminal count and wrap pulse.
// Build option: define UPDOWN_COUNTER_SATURATE_EN to saturate at the bounds instead of wrapping.
module param_updown_counter
    import param_updown_counter_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MODULUS   = DEF_MODULUS,
    parameter int RESET_VAL = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] out_o,
    output logic             tc_o,
    output logic             wrapped_o,
    output logic             zero_o
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
    // One extra bit so MODULUS == 2^WIDTH still compares correctly against load_val.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] out_q, out_d;
    logic             wrapped_q, wrapped_d;
    logic             at_max, at_min, load_clamp;

    assign at_max     = (out_q == MAX_VAL);
    assign at_min     = (out_q == '0);
    assign load_clamp = ({1'b0, load_val_i} >= MOD_EXT);

    always_comb begin
        out_d     = out_q;
        wrapped_d = 1'b0;
        if (load_i) begin
            out_d = load_clamp ? MAX_VAL : load_val_i;
        end else if (en_i) begin
            if (up_i == DIR_UP) begin
                if (at_max) begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
                    out_d     = out_q;
`else
                    out_d     = '0;
                    wrapped_d = 1'b1;
`endif
                end else begin
                    out_d = out_q + WIDTH'(1);
                end
            end else begin
                if (at_min) begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
                    out_d     = out_q;
`else
                    out_d     = MAX_VAL;
                    wrapped_d = 1'b1;
`endif
                end else begin
                    out_d = out_q - WIDTH'(1);
                end
            end
        end
    end

    dff_bank_arst #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) u_out_reg (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (out_d),
        .q_o    (out_q)
    );

    dff_bank_arst #(
        .WIDTH   (1),
        .RST_VAL (1'b0)
    ) u_wrapped_reg (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (wrapped_d),
        .q_o    (wrapped_q)
    );

    // tc marks the cycle before a wrap so it can drive a higher-order counter's enable.
    assign tc_o      = en_i & ~load_i & ((up_i & at_max) | (~up_i & at_min));
    assign zero_o    = at_min;
    assign out_o     = out_q;
    assign wrapped_o = wrapped_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: a modulus-16 and a modulus-10 instance share clock and reset.
module tb_param_updown_counter;

    logic       clk;
    logic       rst_n;

    logic       en16, up16, load16;
    logic [3:0] lv16, out16;
    logic       tc16, wr16, z16;

    logic       en10, up10, load10;
    logic [3:0] lv10, out10;
    logic       tc10, wr10, z10;

    int n_checks = 0;
    int n_pass   = 0;

    param_updown_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) dut16 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en16),
        .up_i       (up16),
        .load_i     (load16),
        .load_val_i (lv16),
        .out_o      (out16),
        .tc_o       (tc16),
        .wrapped_o  (wr16),
        .zero_o     (z16)
    );

    param_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut10 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en10),
        .up_i       (up10),
        .load_i     (load10),
        .load_val_i (lv10),
        .out_o      (out10),
        .tc_o       (tc10),
        .wrapped_o  (wr10),
        .zero_o     (z10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_v;
        rst_n  = 1'b0;
        en16   = 1'b0; up16 = 1'b0; load16 = 1'b0; lv16 = 4'd0;
        en10   = 1'b0; up10 = 1'b0; load10 = 1'b0; lv10 = 4'd0;

        // reset held, then released
        tick(); tick();
        check("rst_out",  32'(out16), 0);
        check("rst_zero", 32'(z16),   1);
        check("rst_wrap", 32'(wr16),  0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_out",  32'(out16), 0);
        check("post_rst_zero", 32'(z16),   1);

        // down count from 0 through a full cycle and one more wrap
        en16 = 1'b1; up16 = 1'b0;
        #1;
        check("down_tc_at0", 32'(tc16), 1);
        for (int i = 1; i <= 17; i++) begin
            tick();
            exp_v = (16 - (i % 16)) % 16;
            check($sformatf("down_out_%0d", i),  32'(out16), 32'(exp_v));
            check($sformatf("down_wrap_%0d", i), 32'(wr16),  32'(exp_v == 15));
            check($sformatf("down_tc_%0d", i),   32'(tc16),  32'(exp_v == 0));
        end

        // async reset pulse between edges
        en16 = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out",  32'(out16), 0);
        check("async_rst_zero", 32'(z16),   1);
        check("async_rst_wrap", 32'(wr16),  0);
        #1 rst_n = 1'b1;
        en16 = 1'b1; up16 = 1'b1;
        tick();
        check("first_edge_after_rst", 32'(out16), 1);
        en16 = 1'b0;

        // modulus 10 up count
        en10 = 1'b1; up10 = 1'b1;
        #1;
        for (int i = 1; i <= 11; i++) begin
            check($sformatf("mod_tc_pre_%0d", i), 32'(tc10), 32'(((i - 1) % 10) == 9));
            tick();
            exp_v = i % 10;
            check($sformatf("mod_out_%0d", i),  32'(out10), 32'(exp_v));
            check($sformatf("mod_wrap_%0d", i), 32'(wr10),  32'(exp_v == 0));
        end

        // load priority and clamp
        en10 = 1'b0; load10 = 1'b1; lv10 = 4'd5;
        tick();
        check("load_5", 32'(out10), 5);
        en10 = 1'b1; up10 = 1'b1; lv10 = 4'd12;
        tick();
        check("load_clamp_12", 32'(out10), 9);
        check("tc_masked_by_load", 32'(tc10), 0);
        lv10 = 4'd10;
        tick();
        check("load_clamp_eq_mod", 32'(out10), 9);
        en10 = 1'b0; lv10 = 4'd3;
        tick();
        check("load_3", 32'(out10), 3);
        load10 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold_%0d", i), 32'(out10), 3);
            check($sformatf("hold_wrap_%0d", i), 32'(wr10), 0);
        end

        // direction toggle every cycle from 7
        load10 = 1'b1; lv10 = 4'd7;
        tick();
        load10 = 1'b0; en10 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up10 = (i % 2 == 0);
            tick();
            check($sformatf("dir_%0d", i), 32'(out10), (i % 2 == 0) ? 8 : 7);
        end
        en10 = 1'b0;

        // down from 2 past the lower bound
        load16 = 1'b1; lv16 = 4'd2;
        tick();
        check("sat_load_2", 32'(out16), 2);
        load16 = 1'b0; en16 = 1'b1; up16 = 1'b0;
        for (int i = 1; i <= 5; i++) begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
            exp_v = (i >= 2) ? 0 : 1;
`else
            exp_v = (2 - i + 16) % 16;
`endif
            tick();
            check($sformatf("bound_out_%0d", i), 32'(out16), 32'(exp_v));
            check($sformatf("bound_tc_%0d", i),  32'(tc16),  32'(exp_v == 0));
`ifdef UPDOWN_COUNTER_SATURATE_EN
            check($sformatf("bound_wrap_%0d", i), 32'(wr16), 0);
`else
            check($sformatf("bound_wrap_%0d", i), 32'(wr16), 32'(exp_v == 15));
`endif
        end
        en16 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
